uart_program_loader: RTL and testbench

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/uart_loader_pkg.sv | 23 ++
 rtl/loader_word_assembler.sv | 51 +++++
 rtl/uart_program_loader.sv | 147 ++++++++++++++
 tb/tb_uart_program_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding,
// frame constants and the running-checksum helper.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

  function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                             input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs received bytes little-endian into 32-bit words and keeps the XOR
// checksum over every data byte of the frame.
module loader_word_assembler
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_last,
  output logic [7:0]  csum
);

  localparam logic [1:0] IDX_LAST = 2'(WORD_BYTES - 1);

  logic [31:0] word_r;
  logic [1:0]  idx_r;
  logic [7:0]  csum_r;

  // Word as it will look once the current byte lands in its lane.
  always_comb begin
    word_next = word_r;
    word_next[{idx_r, 3'b000} +: 8] = byte_in;
    word_last = byte_valid && (idx_r == IDX_LAST);
    csum      = csum_r;
  end

  // Lane index, partial word and checksum registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r <= 32'd0;
      idx_r  <= 2'd0;
      csum_r <= 8'd0;
    end else if (clear) begin
      word_r <= 32'd0;
      idx_r  <= 2'd0;
      csum_r <= 8'd0;
    end else if (byte_valid) begin
      word_r <= word_next;
      idx_r  <= idx_r + 2'd1;
      csum_r <= csum_update(csum_r, byte_in);
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
      csum_r <= csum_r;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a framed program image over a UART byte stream and writes it
// word by word into memory, holding the CPU until the load completes.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_t             state_r;
  logic [7:0]         len_r;
  logic [7:0]         word_cnt_r;
  logic [7:0]         cnt_inc_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               asm_clear_s;
  logic               asm_valid_s;
  logic [31:0]        word_next_s;
  logic               word_last_s;
  logic [7:0]         csum_s;

  // Address of the word being written wraps naturally at ADDR_W bits.
  always_comb begin
    cnt_inc_s   = word_cnt_r + 8'd1;
    addr_s      = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_r);
    asm_clear_s = rx_done && (state_r == ST_LEN);
    asm_valid_s = rx_done && (state_r == ST_DATA);
  end

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear_s),
    .byte_valid (asm_valid_s),
    .byte_in    (rx_data),
    .word_next  (word_next_s),
    .word_last  (word_last_s),
    .csum       (csum_s)
  );

  // Frame FSM and memory write handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      len_r      <= 8'd0;
      word_cnt_r <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_hold <= 1'b0;
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state_r  <= ST_LEN;
            cpu_hold <= 1'b1;
          end
        end
        ST_LEN: begin
          if (rx_done) begin
            len_r      <= rx_data;
            word_cnt_r <= 8'd0;
            if (rx_data == 8'd0) begin
              state_r  <= ST_ERROR;
              load_err <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_last_s) begin
            state_r   <= ST_WRITE;
            mem_we    <= 1'b1;
            mem_addr  <= addr_s;
            mem_wdata <= word_next_s;
          end
        end
        ST_WRITE: begin
          // A byte arriving before the write retires is an overrun.
          if (mem_ready) begin
            mem_we     <= 1'b0;
            word_cnt_r <= cnt_inc_s;
            if (rx_done) begin
              state_r  <= ST_ERROR;
              load_err <= 1'b1;
            end else if (cnt_inc_s == len_r) begin
              state_r <= ST_CSUM;
            end else begin
              state_r <= ST_DATA;
            end
          end else if (rx_done) begin
            mem_we   <= 1'b0;
            state_r  <= ST_ERROR;
            load_err <= 1'b1;
          end
        end
        ST_CSUM: begin
          if (rx_done) begin
            if (rx_data == csum_s) begin
              state_r   <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state_r  <= ST_ERROR;
              load_err <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          load_done <= 1'b0;
          cpu_hold  <= 1'b0;
          state_r   <= ST_IDLE;
        end
        ST_ERROR: begin
          mem_we   <= 1'b0;
          cpu_hold <= 1'b1;
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state_r  <= ST_LEN;
            load_err <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_we    <= 1'b0;
          cpu_hold  <= 1'b0;
          load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised frame stimulus for two loader instances (base 0 and base 254),
// checked against an expected-write queue built from the frame format.
module tb_uart_program_loader;
  import uart_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_we0, mem_we1;
  logic [7:0]  mem_addr0, mem_addr1;
  logic [31:0] mem_wdata0, mem_wdata1;
  logic        cpu_hold0, cpu_hold1;
  logic        load_done0, load_done1;
  logic        load_err0, load_err1;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int d0;
  logic [39:0] exp0[$], exp1[$], got0[$], got1[$];
  logic [31:0] frame_q[$];
  logic [31:0] w;
  logic [31:0] held_data;

  uart_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .mem_ready(mem_ready), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .cpu_hold(cpu_hold0), .load_done(load_done0),
    .load_err(load_err0));

  uart_program_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .mem_ready(mem_ready), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .cpu_hold(cpu_hold1), .load_done(load_done1),
    .load_err(load_err1));

  initial forever #5 clk = ~clk;

  // Record every completed memory handshake and load_done cycle.
  always @(negedge clk) begin
    if (mem_we0 && mem_ready) got0.push_back({mem_addr0, mem_wdata0});
    if (mem_we1 && mem_ready) got1.push_back({mem_addr1, mem_wdata1});
    if (load_done0) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    cyc();
    rx_done = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic add_expect(input int idx, input logic [31:0] data);
    exp0.push_back({8'(idx), data});
    exp1.push_back({8'((254 + idx) % 256), data});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count0"}, 64'(got0.size()), 64'(exp0.size()));
    chk({tag, "_count1"}, 64'(got1.size()), 64'(exp1.size()));
    for (int i = 0; i < exp0.size(); i++)
      if (i < got0.size()) chk({tag, "_wr0"}, 64'(got0[i]), 64'(exp0[i]));
    for (int i = 0; i < exp1.size(); i++)
      if (i < got1.size()) chk({tag, "_wr1"}, 64'(got1[i]), 64'(exp1[i]));
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
  endtask

  // Sends SYNC, length, little-endian words of frame_q and the XOR checksum.
  task automatic send_frame(input bit bad, input int gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'd0;
    send_byte(SYNC_BYTE, gap);
    send_byte(8'(frame_q.size()), gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(frame_q[i] >> (8 * k));
        cs = cs ^ b;
        send_byte(b, gap);
      end
      add_expect(i, frame_q[i]);
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, gap);
    repeat (3) cyc();
  endtask

  task automatic good_frame(input string tag);
    d0 = done_cnt;
    send_frame(1'b0, $urandom_range(1, 3));
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_err"}, 64'(load_err0), 64'd0);
    chk({tag, "_hold"}, 64'(cpu_hold0), 64'd0);
    check_writes(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 64'({mem_we0, mem_we1}), 64'd0);
    chk({tag, "_addr"}, 64'({mem_addr0, mem_addr1}), 64'd0);
    chk({tag, "_wdata"}, 64'({mem_wdata0, mem_wdata1}), 64'd0);
    chk({tag, "_flags"}, 64'({cpu_hold0, load_done0, load_err0, cpu_hold1, load_done1, load_err1}), 64'd0);
    chk({tag, "_state"}, 64'(dut0.state_r), 64'(ST_IDLE));
  endtask

  initial begin
    #12;
    check_zero("reset");
    cyc();
    reset = 1'b1;
    cyc();

    frame_q = '{32'h00000013};
    good_frame("one_word");

    frame_q = '{32'h00500093, 32'h00100113};
    good_frame("two_word");

    frame_q = '{32'h00500093, 32'h00100113};
    d0 = done_cnt;
    send_frame(1'b1, 1);
    chk("bad_csum_err", 64'(load_err0), 64'd1);
    chk("bad_csum_hold", 64'(cpu_hold0), 64'd1);
    chk("bad_csum_done", 64'(done_cnt - d0), 64'd0);
    check_writes("bad_csum");
    good_frame("recover_csum");

    frame_q = '{$urandom(), $urandom(), $urandom()};
    good_frame("wrap3");

    for (int f = 0; f < 4; f++) begin
      frame_q.delete();
      repeat ($urandom_range(1, 6)) frame_q.push_back($urandom());
      good_frame("random");
    end

    send_byte(8'h3C, 1);
    chk("idle_ignore_hold", 64'(cpu_hold0), 64'd0);
    send_byte(SYNC_BYTE, 1);
    chk("len_hold", 64'(cpu_hold0), 64'd1);
    send_byte(8'd0, 1);
    chk("len0_err", 64'(load_err0), 64'd1);
    chk("len0_hold", 64'(cpu_hold0), 64'd1);
    frame_q = '{$urandom()};
    good_frame("recover_len0");

    // Stalled write then overrun without mem_ready.
    mem_ready = 1'b0;
    w = $urandom();
    send_byte(SYNC_BYTE, 1);
    send_byte(8'd2, 1);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), 0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_we", 64'(mem_we0), 64'd1);
      chk("stall_addr", 64'({mem_addr0, mem_addr1}), 64'h00FE);
      chk("stall_data", 64'(mem_wdata0), 64'(w));
      cyc();
    end
    send_byte(8'h77, 1);
    chk("overrun_err", 64'(load_err0), 64'd1);
    chk("overrun_we", 64'(mem_we0), 64'd0);
    chk("overrun_hold", 64'(cpu_hold0), 64'd1);
    check_writes("overrun");

    // Overrun in the same cycle as mem_ready still retires the write.
    w = $urandom();
    send_byte(SYNC_BYTE, 1);
    chk("resync_err_clear", 64'(load_err0), 64'd0);
    send_byte(8'd1, 1);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), 0);
    cyc();
    rx_data = 8'h55;
    rx_done = 1'b1;
    mem_ready = 1'b1;
    cyc();
    rx_done = 1'b0;
    add_expect(0, w);
    cyc();
    chk("overrun_rdy_err", 64'(load_err0), 64'd1);
    chk("overrun_rdy_we", 64'(mem_we0), 64'd0);
    check_writes("overrun_rdy");
    frame_q = '{$urandom(), $urandom()};
    good_frame("recover_overrun");

    // Asynchronous reset in the middle of a frame.
    send_byte(SYNC_BYTE, 1);
    send_byte(8'd3, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    cyc();
    reset = 1'b1;
    cyc();
    send_byte(8'h13, 1);
    send_byte(8'h01, 1);
    chk("post_reset_hold", 64'(cpu_hold0), 64'd0);
    chk("post_reset_state", 64'(dut0.state_r), 64'(ST_IDLE));
    check_writes("post_reset");
    frame_q = '{32'h00000013};
    good_frame("post_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
